// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage and a synchronous
// 1-cycle-latency instruction memory.
interface if_fetch_stage_if;
   logic        imem_rd;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;

   modport master (
      output imem_rd,
      output imem_addr,
      input  imem_data
   );

   modport slave (
      input  imem_rd,
      input  imem_addr,
      output imem_data
   );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID register and a one-entry hold
// buffer that catches the in-flight response when decode stalls.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flash_if_id,
   input  logic [31:0]            redirect_pc,
   input  logic                   stall,
   if_fetch_stage_if.master       imem,
   output logic                   id_valid,
   output logic [31:0]            id_pc,
   output logic [31:0]            id_pc_plus4,
   output logic [31:0]            id_instr
);

   // EMPTY: nothing outstanding, RUN: response due this cycle, HOLD: buffer full
   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_RUN,
      ST_HOLD
   } fetch_state_t;

   fetch_state_t state;
   fetch_state_t state_next;

   logic [31:0] pc;
   logic [31:0] req_pc;
   logic [31:0] buf_instr;
   logic [31:0] buf_pc;
   logic [31:0] redirect_aligned;
   logic        issue;
   logic        load_buf;
   logic        load_mem;
   logic        capture;

   assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
   assign imem.imem_rd     = issue;
   assign imem.imem_addr   = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Flush beats stall; only a RUN-state stall has a response worth capturing.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      load_buf   = 1'b0;
      load_mem   = 1'b0;
      capture    = 1'b0;
      if (flash_if_id) begin
         state_next = ST_EMPTY;
      end else if (stall) begin
         if (state == ST_RUN) begin
            capture    = 1'b1;
            state_next = ST_HOLD;
         end
      end else begin
         issue      = !rst;
         load_buf   = (state == ST_HOLD);
         load_mem   = (state == ST_RUN);
         state_next = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         req_pc      <= RESET_PC;
         buf_instr   <= NOP_INSTR;
         buf_pc      <= 32'h0000_0000;
         id_valid    <= 1'b0;
         id_instr    <= NOP_INSTR;
         id_pc       <= 32'h0000_0000;
         id_pc_plus4 <= 32'h0000_0004;
      end else if (flash_if_id) begin
         pc       <= redirect_aligned;
         id_valid <= 1'b0;
         id_instr <= NOP_INSTR;
      end else if (stall) begin
         if (capture) begin
            buf_instr <= imem.imem_data;
            buf_pc    <= req_pc;
         end
      end else begin
         pc     <= pc + 32'd4;
         req_pc <= pc;
         // The buffer is older than anything in flight, so it drains first.
         if (load_buf) begin
            id_valid    <= 1'b1;
            id_instr    <= buf_instr;
            id_pc       <= buf_pc;
            id_pc_plus4 <= buf_pc + 32'd4;
         end else if (load_mem) begin
            id_valid    <= 1'b1;
            id_instr    <= imem.imem_data;
            id_pc       <= req_pc;
            id_pc_plus4 <= req_pc + 32'd4;
         end else begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
         end
      end
   end

endmodule
